// File: rtl/sl_tx_arbiter_pkg.sv
// Shared definitions for the SlTransmitter arbiter.
//   MODE_*          : word-size encodings carried on req_mode / tx_mode
//   sl_arb_state_t  : arbiter FSM state encoding
package sl_tx_arbiter_pkg;

  localparam logic [1:0] MODE_8       = 2'b00;
  localparam logic [1:0] MODE_16      = 2'b01;
  localparam logic [1:0] MODE_32      = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACCEPT,
    ST_BUSY,
    ST_DONE,
    ST_ABORT
  } sl_arb_state_t;

endpackage

// File: rtl/sl_rr_picker.sv
// Combinational round-robin priority encoder.
//   req    in  : request vector
//   last   in  : index of the previous winner; scanning starts one above it
//   valid  out : at least one request is set
//   winner out : first set request found scanning upward from last+1, wrapping
module sl_rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set
  // request is the final assignment and therefore the winner.
  always_comb begin
    valid  = 1'b0;
    winner = last;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/sl_tx_arbiter.sv
// Round-robin arbiter sharing one SlTransmitter between NUM_REQ requesters.
// Latches the winning word/mode, sequences enable -> accept -> completion and
// returns a per-requester ack (with err on failure). A watchdog aborts a
// transfer if the transmitter stalls in WAIT_ACCEPT or BUSY.
//   clock, reset_n      : core clock, async active-low reset
//   arb_en              : gate for new grants (in-flight transfer completes)
//   req/req_data/req_mode : per-requester request level, word and mode
//   ack, err            : one-cycle completion pulse / failure flag
//   busy, grant_id      : FSM not idle / current or last winner
//   tx_ready            : transmitter idle (synchronous to clock)
//   tx_enable, tx_data, tx_mode : start pulse and latched word/mode
//
// state          | meaning
// ST_IDLE        | waiting for arb_en, a request and an idle transmitter
// ST_START       | tx_enable high for this single cycle
// ST_WAIT_ACCEPT | waiting for tx_ready to fall (transmitter took the word)
// ST_BUSY        | waiting for tx_ready to return (transfer finished)
// ST_DONE        | ack issued, err low
// ST_ABORT       | ack issued, err high (watchdog expired)
module sl_tx_arbiter
  import sl_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = 255,
  localparam int IW         = $clog2(NUM_REQ),
  localparam int WW         = $clog2(TIMEOUT + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]          req_mode,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          err,
  output logic                          busy,
  output logic [IW-1:0]                 grant_id,
  input  logic                          tx_ready,
  output logic                          tx_enable,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [1:0]                    tx_mode
);

  sl_arb_state_t state, next_state;

  logic [WW-1:0]         wdog, wdog_next, wdog_inc;
  logic                  pick_valid;
  logic [IW-1:0]         pick_id;
  logic [DATA_WIDTH-1:0] pick_data;
  logic [1:0]            pick_mode;
  logic                  grant_load, data_load;
  logic [NUM_REQ-1:0]    ack_next;
  logic                  err_next;
  logic [NUM_REQ-1:0]    one_hot_pick, one_hot_grant;

  sl_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .last   (grant_id),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_comb begin
    pick_data = '0;
    pick_mode = MODE_8;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == IW'(i)) begin
        pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        pick_mode = req_mode[i*2 +: 2];
      end
    end
  end

  assign one_hot_pick  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
  assign one_hot_grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

  // Saturating so the counter can never wrap past the compare value.
  assign wdog_inc = (wdog == {WW{1'b1}}) ? wdog : wdog + 1'b1;

  always_comb begin
    next_state = state;
    wdog_next  = wdog;
    grant_load = 1'b0;
    data_load  = 1'b0;
    ack_next   = '0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_en && pick_valid && tx_ready) begin
          grant_load = 1'b1;
          // An illegal mode is rejected on the spot: ack+err, no transfer.
          if (pick_mode == MODE_ILLEGAL) begin
            ack_next = one_hot_pick;
            err_next = 1'b1;
          end else begin
            data_load  = 1'b1;
            next_state = ST_START;
          end
        end
      end
      ST_START: begin
        wdog_next  = '0;
        next_state = ST_WAIT_ACCEPT;
      end
      ST_WAIT_ACCEPT: begin
        if (!tx_ready) begin
          wdog_next  = '0;
          next_state = ST_BUSY;
        end else begin
          wdog_next = wdog_inc;
          if (wdog_inc == WW'(TIMEOUT)) begin
            next_state = ST_ABORT;
            ack_next   = one_hot_grant;
            err_next   = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (tx_ready) begin
          next_state = ST_DONE;
          ack_next   = one_hot_grant;
        end else begin
          wdog_next = wdog_inc;
          if (wdog_inc == WW'(TIMEOUT)) begin
            next_state = ST_ABORT;
            ack_next   = one_hot_grant;
            err_next   = 1'b1;
          end
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      ST_ABORT: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wdog      <= '0;
      grant_id  <= IW'(NUM_REQ - 1);
      tx_data   <= '0;
      tx_mode   <= MODE_8;
      ack       <= '0;
      err       <= 1'b0;
      tx_enable <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      wdog      <= wdog_next;
      ack       <= ack_next;
      err       <= err_next;
      tx_enable <= (next_state == ST_START);
      busy      <= (next_state != ST_IDLE);
      if (grant_load) grant_id <= pick_id;
      if (data_load) begin
        tx_data <= pick_data;
        tx_mode <= pick_mode;
      end
    end
  end

endmodule

// File: tb/tb_sl_tx_arbiter.sv
// Testbench for sl_tx_arbiter: scoreboard of expected transfers, monitor,
// transmitter model and directed plus randomized requester stimulus.
module tb_sl_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 50;
  localparam int IW      = $clog2(NUM_REQ);

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic                   arb_en;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ*2-1:0]   req_mode;
  logic [NUM_REQ-1:0]     ack;
  logic                   err;
  logic                   busy;
  logic [IW-1:0]          grant_id;
  logic                   tx_ready;
  logic                   tx_enable;
  logic [DW-1:0]          tx_data;
  logic [1:0]             tx_mode;

  sl_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .arb_en    (arb_en),
    .req       (req),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .grant_id  (grant_id),
    .tx_ready  (tx_ready),
    .tx_enable (tx_enable),
    .tx_data   (tx_data),
    .tx_mode   (tx_mode)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic [1:0]    mode;
    bit            err;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // shared state between processes
  int  ack_count = 0;
  int  en_total  = 0;
  int  ack_cyc   = 0;
  int  xfer_len  = 0;
  int  rise_cyc  = 0;
  bit  hung      = 1'b0;
  int  drop_dly  = 2;
  int  busy_len  = 10;

  // reference model state
  int  model_last = NUM_REQ - 1;
  int  exp_acks   = 0;
  logic [DW-1:0] d_tab [NUM_REQ];
  logic [1:0]    m_tab [NUM_REQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ---------------- transmitter model ----------------
  initial begin : tx_model
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (!reset_n) begin
        tx_ready = 1'b1;
        phase = 0;
      end else begin
        case (phase)
          0: if (tx_enable && !hung) begin cnt = drop_dly; phase = 1; end
          1: begin
            cnt--;
            if (cnt == 0) begin tx_ready = 1'b0; cnt = busy_len; phase = 2; end
          end
          default: begin
            cnt--;
            if (cnt == 0) begin tx_ready = 1'b1; rise_cyc = cyc; phase = 0; end
          end
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t e;
    int enables;
    int busy_gaps;
    int en_cyc;
    bit in_xfer;
    enables = 0; busy_gaps = 0; en_cyc = 0; in_xfer = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!reset_n) begin
        enables = 0; busy_gaps = 0; in_xfer = 1'b0;
      end else begin
        if (tx_enable) begin
          if (sb.size() == 0) check("unexpected_enable", 64'(tx_enable), 64'(0));
          else begin
            check("tx_data_at_start", 64'(tx_data), 64'(sb[0].data));
            check("tx_mode_at_start", 64'(tx_mode), 64'(sb[0].mode));
            check("grant_id_at_start", 64'(grant_id), 64'(sb[0].id));
          end
          enables++;
          en_total++;
          in_xfer = 1'b1;
          en_cyc = cyc;
          busy_gaps = 0;
        end
        if (in_xfer && !busy) busy_gaps++;
        if (ack != '0) begin
          if (sb.size() == 0) check("unexpected_ack", 64'(ack), 64'(0));
          else begin
            e = sb.pop_front();
            check("ack_vector", 64'(ack), 64'(1) << e.id);
            check("err_flag", 64'(err), 64'(e.err));
            check("grant_id_at_ack", 64'(grant_id), 64'(e.id));
            check("enable_pulses", 64'(enables), (e.mode == 2'b11) ? 64'(0) : 64'(1));
            if (e.mode != 2'b11) begin
              check("tx_data_at_ack", 64'(tx_data), 64'(e.data));
              check("busy_during_xfer", 64'(busy_gaps), 64'(0));
            end
          end
          xfer_len = cyc - en_cyc;
          ack_cyc = cyc;
          enables = 0;
          in_xfer = 1'b0;
          ack_count++;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clock); #2;
    req = req & ~ack;
  endtask

  // Reference model: service order is a rotating scan of the pending set
  // starting just after the previous winner.
  task automatic issue(input logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] pend;
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i]) begin
        req_data[i*DW +: DW] = d_tab[i];
        req_mode[i*2 +: 2]   = m_tab[i];
      end
    end
    pend = mask;
    while (pend != '0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (model_last + k) % NUM_REQ;
        if (pend[c]) begin
          e.id = c;
          e.data = d_tab[c];
          e.mode = m_tab[c];
          e.err = (m_tab[c] == 2'b11) || hung;
          sb.push_back(e);
          pend[c] = 1'b0;
          model_last = c;
          exp_acks++;
          break;
        end
      end
    end
    req = req | mask;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (ack_count < target && n < budget) begin
      step();
      n++;
    end
    check("ack_within_budget", 64'(ack_count >= target), 64'(1));
  endtask

  task automatic wait_busy_phase();
    int n;
    n = 0;
    while (tx_ready && n < 50) begin step(); n++; end
    check("tx_reached_busy", 64'(tx_ready), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int a0, e0;
    reset_n = 1'b0;
    arb_en = 1'b1;
    req = '0;
    req_data = '0;
    req_mode = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tx_enable", 64'(tx_enable), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_tx_mode", 64'(tx_mode), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(NUM_REQ - 1));
    #1;
    reset_n = 1'b1;
    step();

    // round-robin from reset: 0,1,2,3 then 0,2
    drop_dly = 1; busy_len = 3;
    for (int i = 0; i < NUM_REQ; i++) begin d_tab[i] = 32'h1000_0000 + i; m_tab[i] = 2'b01; end
    issue(4'b1111);
    wait_acks(exp_acks, 400);
    check("rr_grant_id_after_round", 64'(grant_id), 64'(3));
    issue(4'b0101);
    wait_acks(exp_acks, 200);

    // single request with 40-cycle transmitter busy time
    drop_dly = 2; busy_len = 40;
    d_tab[0] = 32'hA5A5_1234; m_tab[0] = 2'b10;
    issue(4'b0001);
    wait_acks(exp_acks, 200);
    check("ready_to_ack_latency", 64'(ack_cyc - rise_cyc), 64'(1));

    // illegal mode
    m_tab[2] = 2'b11; d_tab[2] = 32'hDEAD_BEEF;
    issue(4'b0100);
    wait_acks(exp_acks, 50);
    check("illegal_grant_id", 64'(grant_id), 64'(2));

    // hung transmitter, then a normal transfer
    hung = 1'b1;
    d_tab[3] = 32'h0BAD_F00D; m_tab[3] = 2'b00;
    issue(4'b1000);
    wait_acks(exp_acks, 300);
    check("watchdog_enable_to_ack", 64'(xfer_len), 64'(TIMEOUT + 1));
    hung = 1'b0;
    drop_dly = 1; busy_len = 5;
    d_tab[1] = 32'h1111_2222; m_tab[1] = 2'b10;
    issue(4'b0010);
    wait_acks(exp_acks, 200);

    // data changed after grant must not reach tx_data
    drop_dly = 2; busy_len = 8;
    d_tab[0] = 32'hCAFE_0001; m_tab[0] = 2'b10;
    issue(4'b0001);
    for (int n = 0; n < 10 && !tx_enable; n++) step();
    req_data[0 +: DW] = 32'h5555_AAAA;
    wait_acks(exp_acks, 200);

    // arb_en cleared during BUSY
    busy_len = 20;
    d_tab[0] = 32'h0A0A_0A0A; m_tab[0] = 2'b01;
    issue(4'b0001);
    wait_busy_phase();
    arb_en = 1'b0;
    d_tab[1] = 32'h0B0B_0B0B; m_tab[1] = 2'b00;
    issue(4'b0010);
    wait_acks(exp_acks - 1, 200);
    a0 = ack_count; e0 = en_total;
    repeat (20) step();
    check("arb_en_off_no_grant", 64'(en_total - e0), 64'(0));
    check("arb_en_off_no_ack", 64'(ack_count - a0), 64'(0));
    check("arb_en_off_idle", 64'(busy), 64'(0));
    arb_en = 1'b1;
    wait_acks(exp_acks, 200);

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      logic [NUM_REQ-1:0] mask;
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        d_tab[i] = $urandom;
        m_tab[i] = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      drop_dly = $urandom_range(1, 3);
      busy_len = $urandom_range(1, 20);
      issue(mask);
      wait_acks(exp_acks, 600);
    end

    // reset in the middle of BUSY
    drop_dly = 1; busy_len = 30;
    d_tab[3] = 32'h7777_8888; m_tab[3] = 2'b10;
    issue(4'b1000);
    wait_busy_phase();
    step(); step();
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_ack", 64'(ack), 64'(0));
    check("async_rst_err", 64'(err), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_tx_enable", 64'(tx_enable), 64'(0));
    check("async_rst_tx_data", 64'(tx_data), 64'(0));
    check("async_rst_tx_mode", 64'(tx_mode), 64'(0));
    check("async_rst_grant_id", 64'(grant_id), 64'(NUM_REQ - 1));
    sb.delete();
    req = '0;
    model_last = NUM_REQ - 1;
    exp_acks = ack_count;
    a0 = ack_count;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (5) step();
    check("no_ack_across_reset", 64'(ack_count - a0), 64'(0));
    drop_dly = 1; busy_len = 4;
    d_tab[1] = 32'h0000_0101; m_tab[1] = 2'b00;
    d_tab[2] = 32'h0000_0202; m_tab[2] = 2'b01;
    issue(4'b0110);
    wait_acks(exp_acks, 200);

    repeat (3) step();
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog_guard
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish, %0d checks so far", tests);
    $fatal(1);
  end

endmodule
